pulse_width_demodulator: RTL and testbench
==========================================

# pulse_width_demodulator

Measures an incoming PWM waveform, the inverse of the team's PWM generator. For each complete period it recovers the high time and the period length in clock cycles. It detects a constant level (0 % / 100 % duty) through a timeout. Uses: loopback self-test of the DAC's PWM stage, and capture of external PWM control inputs. Results leave as one-cycle strobed samples with no backpressure.

## Interface
- `BITS`, 11, width of the counters and outputs. Maximum measurable period is 2^BITS-1 cycles.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `pwm_in`  in  1  PWM waveform under measurement
- `sample_valid`  out  1  one-cycle strobe; all outputs below are valid while high
- `high_count`  out  BITS  cycles the input was high within the measured period
- `period`  out  BITS  cycles between consecutive rising edges
- `level_stuck`  out  1  sample is a timeout report, not a measured period
- `stuck_level`  out  1  constant input level for a timeout report

## Operation
- Input path
  - `pwm_in` is registered into `pwm_s`; its previous value is kept in `pwm_p`.
  - rise = `pwm_s & !pwm_p`; fall = `!pwm_s & pwm_p`.
- Counter `cnt` (BITS wide, saturating at 2^BITS-1), per cycle:
  - on rise: set to 1
  - in STUCK, on timeout: set to 1
  - otherwise: increment
- States:
  - SYNC (after reset): `cnt` starts at 0. Rise -> HIGH, no sample emitted; the first partial period is discarded.
  - HIGH: fall -> latch `high_reg <= cnt`, go to LOW. A rise cannot occur in HIGH.
  - LOW: rise -> emit sample (`period=cnt`, `high_count=high_reg`, `level_stuck=0`), go to HIGH.
  - STUCK: rise -> HIGH, no sample emitted (period incomplete).
- Timeout
  - Occurs when `cnt==2^BITS-1` and no edge in that cycle, in SYNC, HIGH, LOW or STUCK.
  - Emits a sample with `level_stuck=1`, `stuck_level=pwm_s`, `period=2^BITS-1`, and `high_count=2^BITS-1` if `pwm_s` else 0.
  - Next state is STUCK with `cnt` restarted at 1, so timeout reports repeat every 2^BITS-1 cycles while the level holds.
- Precedence: an edge in the same cycle as `cnt==2^BITS-1` wins. A period of exactly 2^BITS-1 is reported as a normal sample.
- Width rules
  - `high_count` < `period` for every non-stuck sample.
  - A 1-cycle high or 1-cycle low pulse is measured exactly.
- Outputs are registered. They hold their last values between strobes.

## Timing
- Reset values:
  - `sample_valid`, `high_count`, `period`, `level_stuck`, `stuck_level` = 0
  - state = SYNC, `cnt` = 0, `pwm_s` = `pwm_p` = 0
- Latency (without the config macro)
  - A rising edge of `pwm_in` sampled at clock edge k is detected in cycle k+1.
  - The resulting `sample_valid` is high in the cycle after clock edge k+2.
  - The config macro adds 2 cycles to this latency.
- `sample_valid` is high for exactly one cycle per sample, with no handshake. Consumers must capture it on the strobe.
- Reset asserted mid-period:
  - the pending measurement is dropped and no strobe is emitted;
  - after reset deasserts, the block behaves as from power-up.
- Measurement agreement: a single-slope generator with `compare_max=M` and `pulse_width=W` (0<W≤M) must measure as `period=M+1`, `high_count=W`.

## Configuration
- `PWM_DEMOD_SYNC_EN` defined:
  - `pwm_in` passes through a 2-flop synchronizer before `pwm_s`;
  - all detection latencies grow by 2 cycles;
  - measured values are unchanged;
  - required for asynchronous external inputs.
- Not defined: `pwm_in` must be synchronous to `clk` (internal loopback only).

## Test plan
- BITS=11, period 100 with 30 high, repeated:
  - first partial period produces no sample;
  - then every 100 cycles one strobe with `period=100`, `high_count=30`, `level_stuck=0`.
- 1-cycle high pulse every 5 cycles -> `period=5`, `high_count=1`. Then 4-high/1-low -> `period=5`, `high_count=4`.
- Input held high after reset:
  - strobe at `cnt` saturation with `level_stuck=1`, `stuck_level=1`, `high_count=2047`, `period=2047`;
  - repeats every 2047 cycles.
  - Same test with input held low: `stuck_level=0`, `high_count=0`.
- Period of exactly 2047 cycles -> normal sample `period=2047` with no stuck report. Period 2048 -> stuck report, then no sample for the broken period.
- Reset pulsed halfway through a 100-cycle period -> no strobe for that period. The first valid strobe arrives one full period after the first post-reset rise.
- Loopback from the PWM generator (single slope, `compare_max=255`, `pulse_width` 0..255):
  - check `period=256` and `high_count=pulse_width`;
  - `pulse_width=0` gives `stuck_level=0`;
  - repeat with `PWM_DEMOD_SYNC_EN` and check the 2-cycle latency shift.

Source files
------------

// File: rtl/pulse_width_demodulator.sv
// ---------------------------------------------------------------------------
// PulseWidthDemodulator
//
// Measures a PWM waveform. For every complete period (rising edge to rising
// edge) it reports the high time and the period length in clock cycles. A
// level that stays constant for 2^BITS-1 cycles is reported as a timeout
// ("stuck") sample instead, and that report repeats while the level holds.
//
// Parameters:
//   BITS          width of the cycle counter and of the measurement outputs
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   pwm_in        PWM waveform under measurement
//   sample_valid  one-cycle strobe, the outputs below are valid while high
//   high_count    cycles the input was high within the measured period
//   period        cycles between consecutive rising edges
//   level_stuck   sample is a timeout report rather than a measured period
//   stuck_level   constant input level carried by a timeout report
//
// Configuration macro:
//   PWM_DEMOD_SYNC_EN  when defined, pwm_in passes through a 2-flop
//                      synchronizer first (for asynchronous inputs). This
//                      adds 2 cycles of latency and leaves the measured
//                      values unchanged. When undefined, pwm_in must be
//                      synchronous to clk.
// ---------------------------------------------------------------------------
module pulse_width_demodulator #(
  parameter int BITS = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwm_in,
  output logic            sample_valid,
  output logic [BITS-1:0] high_count,
  output logic [BITS-1:0] period,
  output logic            level_stuck,
  output logic            stuck_level
);

  localparam logic [BITS-1:0] CntMax = '1;
  localparam logic [BITS-1:0] CntOne = BITS'(1);

  typedef enum logic [1:0] {
    SYNC,
    HIGH,
    LOW,
    STUCK
  } state_t;

  state_t          state_q;
  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;
  logic [BITS-1:0] high_reg_q;
  logic            pwm_src;
  logic            pwm_s_q;
  logic            pwm_p_q;
  logic            rise;
  logic            fall;
  logic            timeout;

  // Measurement captured by the FSM, one stage ahead of the output registers
  logic            emit_q;
  logic [BITS-1:0] emit_high_q;
  logic [BITS-1:0] emit_period_q;
  logic            emit_stuck_q;
  logic            emit_level_q;

  // Output registers
  logic            valid_q;
  logic [BITS-1:0] high_count_q;
  logic [BITS-1:0] period_q;
  logic            level_stuck_q;
  logic            stuck_level_q;

`ifdef PWM_DEMOD_SYNC_EN
  // Two-flop synchronizer in front of the edge detector, for inputs that
  // are not generated in this clock domain.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

  assign pwm_src = sync_q[1];
`else
  assign pwm_src = pwm_in;
`endif

  // Registered input sample plus its one-cycle-old copy, used for edge
  // detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_s_q <= 1'b0;
      pwm_p_q <= 1'b0;
    end else begin
      pwm_s_q <= pwm_src;
      pwm_p_q <= pwm_s_q;
    end
  end

  assign rise = pwm_s_q & ~pwm_p_q;
  assign fall = ~pwm_s_q & pwm_p_q;

  // A timeout only fires when no edge coincides with the saturated count,
  // so a period of exactly CntMax cycles still measures normally.
  assign timeout = (cnt_q == CntMax) && !rise && !fall;

  // Cycle counter. A rise starts a new period at 1 (the rise cycle itself
  // counts as the first cycle of the new period). A timeout also restarts
  // at 1 so that stuck reports repeat every CntMax cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (rise || timeout) begin
      cnt_d = CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Measurement FSM. SYNC and STUCK wait for a rise without reporting,
  // since the period in progress was not observed from its start. HIGH
  // latches the high time at the fall; LOW reports at the next rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      high_reg_q    <= '0;
      emit_q        <= 1'b0;
      emit_high_q   <= '0;
      emit_period_q <= '0;
      emit_stuck_q  <= 1'b0;
      emit_level_q  <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (timeout) begin
        state_q       <= STUCK;
        emit_q        <= 1'b1;
        emit_period_q <= CntMax;
        emit_high_q   <= pwm_s_q ? CntMax : '0;
        emit_stuck_q  <= 1'b1;
        emit_level_q  <= pwm_s_q;
      end else begin
        case (state_q)
          SYNC: begin
            if (rise) begin
              state_q <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              high_reg_q <= cnt_q;
              state_q    <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              emit_q        <= 1'b1;
              emit_period_q <= cnt_q;
              emit_high_q   <= high_reg_q;
              emit_stuck_q  <= 1'b0;
              emit_level_q  <= 1'b0;
              state_q       <= HIGH;
            end
          end
          STUCK: begin
            if (rise) begin
              state_q <= HIGH;
            end
          end
          default: begin
            state_q <= SYNC;
          end
        endcase
      end
    end
  end

  // Output stage: strobe for one cycle per sample, data holds its last
  // value between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      high_count_q  <= '0;
      period_q      <= '0;
      level_stuck_q <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      valid_q <= emit_q;
      if (emit_q) begin
        high_count_q  <= emit_high_q;
        period_q      <= emit_period_q;
        level_stuck_q <= emit_stuck_q;
        stuck_level_q <= emit_level_q;
      end
    end
  end

  assign sample_valid = valid_q;
  assign high_count   = high_count_q;
  assign period       = period_q;
  assign level_stuck  = level_stuck_q;
  assign stuck_level  = stuck_level_q;

endmodule

// File: tb/tb_pulse_width_demodulator.sv
// ---------------------------------------------------------------------------
// TbPulseWidthDemodulator
//
// Self-checking bench for pulse_width_demodulator (BITS=11). Strobed samples
// are collected into a queue with a cycle stamp; each test drives a waveform
// and then compares the collected samples with hand-computed values.
// ---------------------------------------------------------------------------
module tb_pulse_width_demodulator;

  localparam int BITS = 11;
  localparam int MAXC = 2047;
`ifdef PWM_DEMOD_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic            clk;
  logic            reset;
  logic            pwm_in;
  logic            sample_valid;
  logic [BITS-1:0] high_count;
  logic [BITS-1:0] period;
  logic            level_stuck;
  logic            stuck_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int stamp;
    int hc;
    int per;
    int stk;
    int lvl;
  } smp_t;

  smp_t q[$];

  typedef struct {
    int highLen;
    int lowLen;
    int reps;
    int expPeriod;
    int expHigh;
  } vec_t;

  vec_t vecs[8];

  pulse_width_demodulator #(.BITS(BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .sample_valid (sample_valid),
    .high_count   (high_count),
    .period       (period),
    .level_stuck  (level_stuck),
    .stuck_level  (stuck_level)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp, incremented at each rising edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Collect every strobed sample on the falling edge, away from updates
  always @(negedge clk) begin
    smp_t s;
    if (sample_valid) begin
      s.stamp = cyc;
      s.hc    = int'(high_count);
      s.per   = int'(period);
      s.stk   = int'(level_stuck);
      s.lvl   = int'(stuck_level);
      q.push_back(s);
    end
  end

  // Single comparison with failure report
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Hold pwm_in at a level for n cycles; called at #1 after a rising edge
  task automatic drivePwm(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with pwm_in held at the given level, then clear collected samples
  task automatic doReset(input logic lvl);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    pwm_in = lvl;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    q.delete();
  endtask

  // One table vector: reps full periods then a closing rise
  task automatic applyStimulus(input vec_t v, input int idx);
    int closeStamp;
    doReset(1'b0);
    drivePwm(1'b0, 3);
    for (int r = 0; r < v.reps; r++) begin
      drivePwm(1'b1, v.highLen);
      drivePwm(1'b0, v.lowLen);
    end
    closeStamp = cyc;
    drivePwm(1'b1, LAT + 4);
    checkOutput($sformatf("vec%0d count", idx), q.size(), v.reps);
    for (int i = 0; i < q.size() && i < v.reps; i++) begin
      checkOutput($sformatf("vec%0d[%0d] period", idx, i), q[i].per, v.expPeriod);
      checkOutput($sformatf("vec%0d[%0d] high", idx, i), q[i].hc, v.expHigh);
      checkOutput($sformatf("vec%0d[%0d] stuck", idx, i), q[i].stk, 0);
      if (i > 0) begin
        checkOutput($sformatf("vec%0d[%0d] spacing", idx, i), q[i].stamp - q[i-1].stamp, v.expPeriod);
      end
    end
    if (q.size() == v.reps) begin
      checkOutput($sformatf("vec%0d latency", idx), q[q.size()-1].stamp, closeStamp + LAT);
    end
  endtask

  // Constant level after reset: two timeout reports, CntMax cycles apart
  task automatic stuckTest(input logic lvl);
    int relStamp;
    doReset(lvl);
    relStamp = cyc;
    repeat (2 * MAXC + 16) begin
      @(posedge clk);
      #1;
    end
    checkOutput($sformatf("stuck%0d count", lvl), q.size(), 2);
    for (int i = 0; i < q.size() && i < 2; i++) begin
      checkOutput($sformatf("stuck%0d[%0d] flag", lvl, i), q[i].stk, 1);
      checkOutput($sformatf("stuck%0d[%0d] level", lvl, i), q[i].lvl, int'(lvl));
      checkOutput($sformatf("stuck%0d[%0d] high", lvl, i), q[i].hc, lvl ? MAXC : 0);
      checkOutput($sformatf("stuck%0d[%0d] period", lvl, i), q[i].per, MAXC);
    end
    if (q.size() == 2) begin
      checkOutput($sformatf("stuck%0d spacing", lvl), q[1].stamp - q[0].stamp, MAXC);
      checkOutput($sformatf("stuck%0d first", lvl), q[0].stamp,
                  lvl ? relStamp + LAT + MAXC : relStamp + MAXC + 2);
    end
  endtask

  initial begin
    int r0;
    int r1;
    int r2;

    vecs[0] = '{highLen: 30,   lowLen: 70,   reps: 3, expPeriod: 100,  expHigh: 30};
    vecs[1] = '{highLen: 1,    lowLen: 4,    reps: 3, expPeriod: 5,    expHigh: 1};
    vecs[2] = '{highLen: 4,    lowLen: 1,    reps: 3, expPeriod: 5,    expHigh: 4};
    vecs[3] = '{highLen: 1,    lowLen: 1,    reps: 3, expPeriod: 2,    expHigh: 1};
    vecs[4] = '{highLen: 77,   lowLen: 179,  reps: 2, expPeriod: 256,  expHigh: 77};
    vecs[5] = '{highLen: 255,  lowLen: 1,    reps: 2, expPeriod: 256,  expHigh: 255};
    vecs[6] = '{highLen: 1,    lowLen: 255,  reps: 2, expPeriod: 256,  expHigh: 1};
    vecs[7] = '{highLen: 1000, lowLen: 1047, reps: 1, expPeriod: MAXC, expHigh: 1000};

    reset  = 1'b1;
    pwm_in = 1'b0;

    // Reset state
    doReset(1'b0);
    checkOutput("reset valid", int'(sample_valid), 0);
    checkOutput("reset high", int'(high_count), 0);
    checkOutput("reset period", int'(period), 0);
    checkOutput("reset stuck", int'(level_stuck), 0);
    checkOutput("reset level", int'(stuck_level), 0);

    // Table-driven period measurements
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Outputs nonzero now; reset must clear them
    doReset(1'b0);
    checkOutput("rereset high", int'(high_count), 0);
    checkOutput("rereset period", int'(period), 0);

    // Constant high and constant low (pulse_width=0 case)
    stuckTest(1'b1);
    stuckTest(1'b0);

    // Period of 2048: timeout report, broken period dropped, then recovery
    doReset(1'b0);
    drivePwm(1'b0, 3);
    r0 = cyc;
    drivePwm(1'b1, 1000);
    drivePwm(1'b0, 1048);
    drivePwm(1'b1, 30);
    drivePwm(1'b0, 70);
    r1 = cyc;
    drivePwm(1'b1, LAT + 4);
    checkOutput("p2048 count", q.size(), 2);
    if (q.size() == 2) begin
      checkOutput("p2048 stuck", q[0].stk, 1);
      checkOutput("p2048 level", q[0].lvl, 0);
      checkOutput("p2048 high", q[0].hc, 0);
      checkOutput("p2048 period", q[0].per, MAXC);
      checkOutput("p2048 stamp", q[0].stamp, r0 + LAT + MAXC);
      checkOutput("p2048 next period", q[1].per, 100);
      checkOutput("p2048 next high", q[1].hc, 30);
      checkOutput("p2048 next stuck", q[1].stk, 0);
      checkOutput("p2048 next stamp", q[1].stamp, r1 + LAT);
    end

    // Reset pulsed mid-period: that period yields no sample
    doReset(1'b0);
    drivePwm(1'b0, 3);
    drivePwm(1'b1, 30);
    drivePwm(1'b0, 70);
    r0 = cyc;
    drivePwm(1'b1, 30);
    drivePwm(1'b0, 20);
    reset = 1'b1;
    drivePwm(1'b0, 1);
    reset = 1'b0;
    drivePwm(1'b0, 49);
    drivePwm(1'b1, 30);
    drivePwm(1'b0, 70);
    r2 = cyc;
    drivePwm(1'b1, LAT + 4);
    checkOutput("midreset count", q.size(), 2);
    if (q.size() == 2) begin
      checkOutput("midreset first stamp", q[0].stamp, r0 + LAT);
      checkOutput("midreset second stamp", q[1].stamp, r2 + LAT);
      checkOutput("midreset second period", q[1].per, 100);
      checkOutput("midreset second high", q[1].hc, 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
